// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator driving TCK/TMS/TDI and sampling TDO.
// Define JTAG_TDO_FALL_EN to sample TDO on the falling TCK edge.
module jtag_host #(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 4,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int SW = (LW > 3) ? LW : 3;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] T_RST  = 2'b00;
  localparam logic [1:0] T_IR   = 2'b01;
  localparam logic [1:0] T_IDLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RESET_SEQ, NAV_IN, SHIFT,
    NAV_OUT, RUN_IDLE, DONE
  } state_t;

  state_t             state;
  state_t             nxt_state;
  state_t             start_st;
  logic [SW-1:0]      step;
  logic [SW-1:0]      nxt_step;
  logic [SW-1:0]      lenx;
  logic [LW-1:0]      len;
  logic [LW-1:0]      len_c;
  logic [1:0]         typ;
  logic [MAX_LEN-1:0] dat;
  logic [MAX_LEN-1:0] cap;
  logic [MAX_LEN-1:0] cap_in;
  logic [DW-1:0]      div;
  logic               tap_known;
  logic               fin;
  logic               half_end;
  logic               need_rst;
  logic               tms_nxt;

  assign len_c    = (cmd_len > LW'(MAX_LEN)) ?
                    LW'(MAX_LEN) : cmd_len;
  assign lenx     = SW'(len);
  assign half_end = (div == DW'(CLK_DIV - 1));
  assign need_rst = (cmd_type == T_RST) || !tap_known;
  // captured bits enter at the top; first bit ends lowest
  assign cap_in   = MAX_LEN'({tdo, cap} >> 1);

  always_comb begin
    start_st = NAV_IN;
    if (need_rst)
      start_st = RESET_SEQ;
    else if (cmd_type == T_IDLE)
      start_st = RUN_IDLE;
  end

  always_comb begin
    nxt_state = state;
    nxt_step  = step + 1'b1;
    fin       = 1'b0;
    unique case (state)
      RESET_SEQ:
        if (step == SW'(5)) begin
          nxt_step = '0;
          if (typ == T_RST || len == '0)
            fin = 1'b1;
          else if (typ == T_IDLE)
            nxt_state = RUN_IDLE;
          else
            nxt_state = NAV_IN;
        end
      NAV_IN:
        if (step == ((typ == T_IR) ?
                     SW'(3) : SW'(2))) begin
          nxt_state = SHIFT;
          nxt_step  = '0;
        end
      SHIFT:
        if (step == lenx - 1'b1) begin
          nxt_state = NAV_OUT;
          nxt_step  = '0;
        end
      NAV_OUT:
        if (step == SW'(1))
          fin = 1'b1;
      RUN_IDLE:
        if (step == lenx - 1'b1)
          fin = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    tms_nxt = 1'b0;
    unique case (nxt_state)
      RESET_SEQ: tms_nxt = nxt_step < SW'(5);
      NAV_IN:    tms_nxt = (typ == T_IR) ?
                           (nxt_step < SW'(2)) :
                           (nxt_step == '0);
      SHIFT:     tms_nxt = nxt_step == lenx - 1'b1;
      NAV_OUT:   tms_nxt = nxt_step == '0;
      default:   tms_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      div       <= '0;
      len       <= '0;
      typ       <= T_RST;
      dat       <= '0;
      cap       <= '0;
      tap_known <= 1'b0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        typ       <= cmd_type;
        len       <= len_c;
        dat       <= cmd_data;
        cap       <= '0;
        step      <= '0;
        div       <= '0;
        cmd_ready <= 1'b0;
        tck       <= 1'b0;
        tdi       <= 1'b0;
        if (!need_rst && len_c == '0) begin
          state <= DONE;
          tms   <= 1'b0;
        end else begin
          state <= start_st;
          tms   <= (start_st != RUN_IDLE);
        end
      end else if (state == DONE) begin
        state     <= IDLE;
        cmd_ready <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
      end else if (state != IDLE) begin
        div <= half_end ? '0 : div + 1'b1;
        if (half_end) begin
          tck <= !tck;
          if (!tck) begin
`ifndef JTAG_TDO_FALL_EN
            if (state == SHIFT)
              cap <= cap_in;
`endif
          end else begin
`ifdef JTAG_TDO_FALL_EN
            if (state == SHIFT)
              cap <= cap_in;
`endif
            if (state == RESET_SEQ &&
                step == SW'(5))
              tap_known <= 1'b1;
            if (fin) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              rsp_valid <= 1'b1;
              tms       <= 1'b0;
              tdi       <= 1'b0;
              rsp_data  <= cap >>
                           (MAX_LEN - int'(len));
            end else begin
              state <= nxt_state;
              step  <= nxt_step;
              tms   <= tms_nxt;
              tdi   <= (nxt_state == SHIFT) ?
                       dat[0] : 1'b0;
              if (nxt_state == SHIFT)
                dat <= dat >> 1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: randomized scoreboard bench for jtag_host.
// Reference model builds each command's TCK stream from the TAP rules.
module tb_jtag_host;

  localparam int ML = 32;
  localparam int CD = 2;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = 2'b00;
  logic [LW-1:0] cmd_len = '0;
  logic [ML-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [ML-1:0] rsp_data;
  logic          tck;
  logic          tms;
  logic          tdi;
  logic          tdo = 1'b0;

  jtag_host #(.MAX_LEN(ML), .CLK_DIV(CD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ML-1:0] rsp;
    int            n;
    logic [63:0]   ms;
    logic [63:0]   di;
    int            acc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          tap_known = 1'b0;
  int          nrec = 0;
  logic [63:0] rms = '0;
  logic [63:0] rdi = '0;
  logic        ptck = 1'b0;
  logic        tgt = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  // Expected TCK stream: TMS/TDI per period; target echoes TDI one TCK late
  function automatic exp_t model(input logic [1:0] t,
                                 input int l,
                                 input logic [ML-1:0] d);
    exp_t e;
    int   len;
    e.rsp = '0;
    e.n   = 0;
    e.ms  = '0;
    e.di  = '0;
    e.acc = 0;
    len   = (l > ML) ? ML : l;
    if (t == 2'b00 || !tap_known) begin
      for (int i = 0; i < 6; i++) begin
        e.ms[e.n] = (i < 5);
        e.n++;
      end
      tap_known = 1'b1;
    end
    if (t != 2'b00 && len > 0) begin
      if (t == 2'b11) begin
        e.n += len;
      end else begin
        for (int i = 0; i < ((t == 2'b01) ? 4 : 3); i++) begin
          e.ms[e.n] = (t == 2'b01) ? (i < 2) : (i == 0);
          e.n++;
        end
        for (int i = 0; i < len; i++) begin
          e.ms[e.n] = (i == len - 1);
          e.di[e.n] = d[i];
          e.rsp[i]  = e.di[e.n-1];
          e.n++;
        end
        e.ms[e.n] = 1'b1;
        e.n += 2;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      nrec = 0;
      rms  = '0;
      rdi  = '0;
    end else begin
      if (!ptck && tck) begin
        tgt = tdi;
        if (nrec < 64) begin
          rms[nrec] = tms;
          rdi[nrec] = tdi;
        end
        nrec++;
      end
      if (ptck && !tck)
        tdo = tgt;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          me = q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(me.rsp));
          chk("tck_count", 64'(nrec), 64'(me.n));
          chk("tms_seq", rms, me.ms);
          chk("tdi_seq", rdi, me.di);
          chk("latency", 64'(cyc - me.acc),
              64'((me.n == 0) ? 1 : me.n * 2 * CD));
          chk("ready_at_rsp", 64'(cmd_ready), 64'(1));
          chk("idle_line",
              64'({tck, tms, tdi}), 64'(0));
        end
        nrec = 0;
        rms  = '0;
        rdi  = '0;
      end
    end
    ptck = tck;
  end

  task automatic send(input logic [1:0] t, input int l,
                      input logic [ML-1:0] d,
                      input bit push, input bit b2b);
    exp_t e;
    int   w;
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = LW'(l);
    cmd_data  = d;
    w = 0;
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    if (b2b)
      chk("b2b_in_rsp_cycle", 64'(rsp_valid), 64'(1));
    e = model(t, l, d);
    e.acc = cyc + 1;
    if (push)
      q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tap_known = 1'b0;
  endtask

  initial begin
    int w;
    int gap;
    bit b2b;
    logic [1:0] t;
    repeat (2) @(negedge clk);
    chk("rst_tck", 64'(tck), 64'(0));
    chk("rst_tms", 64'(tms), 64'(1));
    chk("rst_tdi", 64'(tdi), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    rst = 1'b0;
    tap_known = 1'b0;
    @(negedge clk);

    send(2'b00, 0, '0, 1'b1, 1'b0);
    send(2'b10, 8, ML'(32'hA5), 1'b1, 1'b1);
    drain();

    do_reset();
    send(2'b01, 4, ML'(32'h3), 1'b1, 1'b0);
    send(2'b11, 3, '0, 1'b1, 1'b1);
    send(2'b10, 0, '0, 1'b1, 1'b1);
    drain();

    send(2'b10, 32, ML'($urandom), 1'b0, 1'b0);
    w = 0;
    while (nrec < 5 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reach_tck5", 64'(nrec >= 5), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tap_known = 1'b0;
    chk("abort_tck", 64'(tck), 64'(0));
    chk("abort_tms", 64'(tms), 64'(1));
    chk("abort_ready", 64'(cmd_ready), 64'(1));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    repeat (20) @(negedge clk);
    send(2'b10, 8, ML'($urandom), 1'b1, 1'b0);
    send(2'b10, 40, ML'($urandom), 1'b1, 1'b1);
    send(2'b11, 2, '0, 1'b1, 1'b1);
    drain();

    b2b = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        drain();
        do_reset();
        b2b = 1'b0;
      end
      t = 2'($urandom_range(0, 3));
      send(t, $urandom_range(0, 40), ML'($urandom),
           1'b1, b2b);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      b2b = (gap == 0);
    end
    drain();
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
